// File: rtl/pwm_multicanal.sv
// pwm_multicanal: N-channel PWM with a shared prescaler and shared R-bit
// period counter. Edge- or center-aligned, with double-buffered duty values.

// One PWM channel: shadow/active duty pair plus the registered output compare.
module pwm_multicanal_ch #(
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         bnd,
  input  logic         en,
  input  logic [R:0]   ciclo_i,
  input  logic [R-1:0] cnt,
  output logic         pwm_o
);

  localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};

  logic [R:0] shadow_q, shadow_d;
  logic [R:0] active_q, active_d;
  logic       out_q, out_d;

  // Clamp on capture, hand shadow to active at the boundary, compare every clock.
  // active still holds the old value on the boundary edge, so a load on that
  // same clock lands one period later.
  always_comb begin
    shadow_d = shadow_q;
    if (load) shadow_d = (ciclo_i > FULL) ? FULL : ciclo_i;
    active_d = bnd ? shadow_q : active_q;
    out_d    = en & ({1'b0, cnt} < active_q);
  end

  // Channel state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      out_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      out_q    <= out_d;
    end
  end

  assign pwm_o = out_q;

endmodule

module pwm_multicanal #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 8,
  parameter int N_CH       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TIMER_BITS-1:0]   final_value,
  input  logic [N_CH*(R+1)-1:0]   ciclo,
  input  logic                    load,
  input  logic                    mode,
  input  logic [N_CH-1:0]         enable,
  output logic [N_CH-1:0]         pwm_out,
  output logic                    period_end
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  localparam logic [TIMER_BITS-1:0] P_ONE   = {{(TIMER_BITS-1){1'b0}}, 1'b1};
  localparam logic [R-1:0]          C_ONE   = {{(R-1){1'b0}}, 1'b1};
  localparam logic [R-1:0]          CNT_MAX = '1;

  logic [TIMER_BITS-1:0] pcnt_q, pcnt_d;
  logic                  tick;
  logic [R-1:0]          cnt_q, cnt_d;
  dir_e                  dir_q, dir_d;
  logic                  mode_act_q, mode_act_d;
  logic                  pe_q, pe_d;
  logic                  bnd;

  // Prescaler: >= compare so lowering final_value mid-count cannot overrun.
  always_comb begin
    tick   = (pcnt_q >= final_value);
    pcnt_d = tick ? '0 : pcnt_q + P_ONE;
  end

  // Period counter / direction FSM; the boundary restarts at cnt=0 going UP
  // and latches the requested mode for the next period.
  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    mode_act_d = mode_act_q;
    bnd        = 1'b0;
    if (tick) begin
      if (!mode_act_q) begin
        if (cnt_q == CNT_MAX) bnd = 1'b1;
        else                  cnt_d = cnt_q + C_ONE;
      end else begin
        case (dir_q)
          UP:      if (cnt_q == CNT_MAX) dir_d = DOWN;
                   else                  cnt_d = cnt_q + C_ONE;
          DOWN:    if (cnt_q == '0)      bnd   = 1'b1;
                   else                  cnt_d = cnt_q - C_ONE;
          default: dir_d = UP;
        endcase
      end
    end
    if (bnd) begin
      cnt_d      = '0;
      dir_d      = UP;
      mode_act_d = mode;
    end
    pe_d = bnd;
  end

  // Shared timing state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q     <= '0;
      cnt_q      <= '0;
      dir_q      <= UP;
      mode_act_q <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      mode_act_q <= mode_act_d;
      pe_q       <= pe_d;
    end
  end

  assign period_end = pe_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_multicanal_ch #(.R(R)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .bnd     (bnd),
      .en      (enable[i]),
      .ciclo_i (ciclo[i*(R+1) +: R+1]),
      .cnt     (cnt_q),
      .pwm_o   (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multicanal.sv
// Bench for pwm_multicanal (R=4, two channels). A phase-based reference model
// pushes the expected {pwm_out, period_end} per clock; each test pops and
// compares, and also checks per-period high counts and period lengths.
module tb_pwm_multicanal;

  localparam int R  = 4;
  localparam int N  = 2;
  localparam int TB = 8;
  localparam int P  = 1 << R;

  logic              clk;
  logic              reset;
  logic [TB-1:0]     final_value;
  logic [N*(R+1)-1:0] ciclo;
  logic              load;
  logic              mode;
  logic [N-1:0]      enable;
  logic [N-1:0]      pwm_out;
  logic              period_end;

  int n_chk  = 0;
  int n_pass = 0;

  logic [2:0] exp_q[$];

  // reference model state: phase = ticks elapsed in the current period
  int m_pcnt, m_phase, m_mode;
  int m_shadow[N];
  int m_active[N];

  pwm_multicanal #(.R(R), .TIMER_BITS(TB), .N_CH(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .final_value (final_value),
    .ciclo       (ciclo),
    .load        (load),
    .mode        (mode),
    .enable      (enable),
    .pwm_out     (pwm_out),
    .period_end  (period_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*(R+1)-1:0] pack(input int a, input int b);
    logic [4:0] fa, fb;
    fa = a[4:0];
    fb = b[4:0];
    return {fb, fa};
  endfunction

  // Advance one clock: model predicts this edge, pushes it, then the edge runs.
  task automatic cyc();
    int plen, cv, v;
    bit tk, bnd;
    logic [N-1:0] ep;
    logic epe;
    ep = '0;
    epe = 1'b0;
    if (reset) begin
      m_pcnt = 0; m_phase = 0; m_mode = 0;
      for (int i = 0; i < N; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    end else begin
      tk   = (m_pcnt >= final_value);
      plen = m_mode ? 2*P : P;
      cv   = (m_mode == 0 || m_phase < P) ? m_phase : 2*P-1-m_phase;
      for (int i = 0; i < N; i++) ep[i] = enable[i] && (cv < m_active[i]);
      bnd = tk && (m_phase == plen-1);
      epe = bnd;
      if (bnd) begin
        for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
        m_mode  = mode;
        m_phase = 0;
      end else if (tk) m_phase++;
      if (load)
        for (int i = 0; i < N; i++) begin
          v = ciclo[i*(R+1) +: R+1];
          m_shadow[i] = (v > P) ? P : v;
        end
      m_pcnt = tk ? 0 : m_pcnt + 1;
    end
    exp_q.push_back({ep, epe});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    int p, len[3], hi[3];
    p = 0;
    foreach (len[i]) begin len[i] = 0; hi[i] = 0; end
    reset = 1; load = 1; ciclo = '1; enable = '1; mode = 0; final_value = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      e = exp_q.pop_front();
      n_chk++;
      if ({pwm_out, period_end} !== 3'b000) $display("FAIL reset_hold got %b need 000", {pwm_out, period_end});
      else n_pass++;
      n_chk++;
      if ({pwm_out, period_end} !== e) $display("FAIL reset_sb got %b need %b", {pwm_out, period_end}, e);
      else n_pass++;
    end
    reset = 0; load = 0;
    for (int c = 0; c < 60 && p < 2; c++) begin
      cyc();
      e = exp_q.pop_front();
      n_chk++;
      if ({pwm_out, period_end} !== e) $display("FAIL reset_sb c=%0d got %b need %b", c, {pwm_out, period_end}, e);
      else n_pass++;
      len[p]++; hi[p] += pwm_out[0] + pwm_out[1];
      if (period_end) p++;
    end
    n_chk++;
    if (p != 2) $display("FAIL reset_timeout periods %0d need 2", p); else n_pass++;
    n_chk++;
    if (len[1] != P) $display("FAIL reset_period len %0d need %0d", len[1], P); else n_pass++;
    n_chk++;
    if (hi[0] + hi[1] != 0) $display("FAIL reset_outputs highs %0d need 0", hi[0] + hi[1]); else n_pass++;
  endtask

  task automatic test_edge();
    logic [2:0] e;
    int p, len[4], h0[4], h1[4];
    p = 0;
    foreach (len[i]) begin len[i] = 0; h0[i] = 0; h1[i] = 0; end
    final_value = 0; mode = 0; enable = 2'b11; ciclo = pack(4, 16); load = 1;
    for (int c = 0; c < 120 && p < 3; c++) begin
      cyc();
      load = 0;
      e = exp_q.pop_front();
      n_chk++;
      if ({pwm_out, period_end} !== e) $display("FAIL edge_sb c=%0d got %b need %b", c, {pwm_out, period_end}, e);
      else n_pass++;
      len[p]++; h0[p] += pwm_out[0]; h1[p] += pwm_out[1];
      if (period_end) p++;
    end
    n_chk++;
    if (p != 3) $display("FAIL edge_timeout periods %0d need 3", p); else n_pass++;
    for (int q = 1; q < 3; q++) begin
      n_chk++;
      if (len[q] != 16) $display("FAIL edge_len p%0d got %0d need 16", q, len[q]); else n_pass++;
      n_chk++;
      if (h0[q] != 4) $display("FAIL edge_ch0_high p%0d got %0d need 4", q, h0[q]); else n_pass++;
      n_chk++;
      if (h1[q] != 16) $display("FAIL edge_ch1_high p%0d got %0d need 16", q, h1[q]); else n_pass++;
    end
  endtask

  task automatic test_prescaler();
    logic [2:0] e;
    int p, len[4], h0[4], h1[4];
    p = 0;
    foreach (len[i]) begin len[i] = 0; h0[i] = 0; h1[i] = 0; end
    final_value = 2; ciclo = pack(8, 16); load = 1;
    for (int c = 0; c < 300 && p < 3; c++) begin
      cyc();
      load = 0;
      e = exp_q.pop_front();
      n_chk++;
      if ({pwm_out, period_end} !== e) $display("FAIL presc_sb c=%0d got %b need %b", c, {pwm_out, period_end}, e);
      else n_pass++;
      len[p]++; h0[p] += pwm_out[0]; h1[p] += pwm_out[1];
      if (period_end) p++;
    end
    n_chk++;
    if (p != 3) $display("FAIL presc_timeout periods %0d need 3", p); else n_pass++;
    for (int q = 1; q < 3; q++) begin
      n_chk++;
      if (len[q] != 48) $display("FAIL presc_len p%0d got %0d need 48", q, len[q]); else n_pass++;
      n_chk++;
      if (h0[q] != 24) $display("FAIL presc_ch0_high p%0d got %0d need 24", q, h0[q]); else n_pass++;
    end
  endtask

  task automatic test_center();
    logic [2:0] e;
    int p, len[4], h0[4], h1[4];
    p = 0;
    foreach (len[i]) begin len[i] = 0; h0[i] = 0; h1[i] = 0; end
    final_value = 0; mode = 1; ciclo = pack(4, 16); load = 1;
    for (int c = 0; c < 200 && p < 3; c++) begin
      cyc();
      load = 0;
      e = exp_q.pop_front();
      n_chk++;
      if ({pwm_out, period_end} !== e) $display("FAIL center_sb c=%0d got %b need %b", c, {pwm_out, period_end}, e);
      else n_pass++;
      len[p]++; h0[p] += pwm_out[0]; h1[p] += pwm_out[1];
      if (period_end && p >= 1) begin
        n_chk++;
        if (pwm_out[0] !== 1'b1) $display("FAIL center_span p%0d ch0 %b need 1", p, pwm_out[0]); else n_pass++;
      end
      if (period_end) p++;
    end
    n_chk++;
    if (p != 3) $display("FAIL center_timeout periods %0d need 3", p); else n_pass++;
    for (int q = 1; q < 3; q++) begin
      n_chk++;
      if (len[q] != 32) $display("FAIL center_len p%0d got %0d need 32", q, len[q]); else n_pass++;
      n_chk++;
      if (h0[q] != 8) $display("FAIL center_ch0_high p%0d got %0d need 8", q, h0[q]); else n_pass++;
      n_chk++;
      if (h1[q] != 32) $display("FAIL center_ch1_high p%0d got %0d need 32", q, h1[q]); else n_pass++;
    end
  endtask

  task automatic test_double_buffer();
    logic [2:0] e;
    int p, k, h0[7];
    int need[7];
    p = 0; k = 0;
    foreach (h0[i]) h0[i] = 0;
    need = '{0, 4, 12, 12, 12, 2, 0};
    mode = 0; ciclo = pack(4, 16); load = 0;
    for (int c = 0; c < 200 && p < 6; c++) begin
      load = 0;
      if (p == 1 && k == 5)  begin load = 1; ciclo = pack(12, 16); end
      if (p == 3 && k == 15) begin load = 1; ciclo = pack(2, 16); end
      cyc();
      e = exp_q.pop_front();
      n_chk++;
      if ({pwm_out, period_end} !== e) $display("FAIL dbuf_sb c=%0d got %b need %b", c, {pwm_out, period_end}, e);
      else n_pass++;
      h0[p] += pwm_out[0];
      if (period_end) begin p++; k = 0; end
      else k++;
    end
    load = 0;
    n_chk++;
    if (p != 6) $display("FAIL dbuf_timeout periods %0d need 6", p); else n_pass++;
    for (int q = 1; q < 6; q++) begin
      n_chk++;
      if (h0[q] != need[q]) $display("FAIL dbuf_ch0_high p%0d got %0d need %0d", q, h0[q], need[q]);
      else n_pass++;
    end
  endtask

  task automatic test_clamp_enable();
    logic [2:0] e;
    int p, k, f8, len[5], h0[5], h1[5];
    p = 0; k = 0; f8 = 0;
    foreach (len[i]) begin len[i] = 0; h0[i] = 0; h1[i] = 0; end
    mode = 0; enable = 2'b11; ciclo = pack(31, 8);
    for (int c = 0; c < 200 && p < 4; c++) begin
      load = (c == 0);
      if (p == 2 && k == 6) enable = 2'b10;
      if (p == 2 && k == 8) mode = 1;
      cyc();
      e = exp_q.pop_front();
      n_chk++;
      if ({pwm_out, period_end} !== e) $display("FAIL clamp_sb c=%0d got %b need %b", c, {pwm_out, period_end}, e);
      else n_pass++;
      len[p]++; h0[p] += pwm_out[0]; h1[p] += pwm_out[1];
      if (p == 3 && k < 8) f8 += pwm_out[1];
      if (period_end) begin p++; k = 0; end
      else k++;
    end
    load = 0;
    n_chk++;
    if (p != 4) $display("FAIL clamp_timeout periods %0d need 4", p); else n_pass++;
    n_chk++;
    if (h0[1] != 16) $display("FAIL clamp_ch0_full got %0d need 16", h0[1]); else n_pass++;
    n_chk++;
    if (h1[1] != 8) $display("FAIL clamp_ch1 got %0d need 8", h1[1]); else n_pass++;
    n_chk++;
    if (h0[2] != 6) $display("FAIL disable_ch0 got %0d need 6", h0[2]); else n_pass++;
    n_chk++;
    if (h1[2] != 8) $display("FAIL disable_ch1 got %0d need 8", h1[2]); else n_pass++;
    n_chk++;
    if (len[2] != 16) $display("FAIL modesw_old_len got %0d need 16", len[2]); else n_pass++;
    n_chk++;
    if (len[3] != 32) $display("FAIL modesw_new_len got %0d need 32", len[3]); else n_pass++;
    n_chk++;
    if (h0[3] != 0) $display("FAIL modesw_ch0_off got %0d need 0", h0[3]); else n_pass++;
    n_chk++;
    if (h1[3] != 16) $display("FAIL modesw_ch1 got %0d need 16", h1[3]); else n_pass++;
    n_chk++;
    if (f8 != 8) $display("FAIL modesw_start_up got %0d need 8", f8); else n_pass++;
  endtask

  initial begin
    reset = 1; load = 0; mode = 0; enable = '0; ciclo = '0; final_value = '0;
    test_reset();
    test_edge();
    test_prescaler();
    test_center();
    test_double_buffer();
    test_clamp_enable();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
